// File: rtl/tensor_pkg.sv
// Shared types and sizing helpers for the byte-serial matrix MAC engine.
package tensor_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_READ    = 2'd3
  } state_e;

  // Bytes needed to carry one N x N operand matrix
  function automatic int unsigned calc_ba(input int unsigned n, input int unsigned ew);
    return (n * n * ew + 32'd7) / 32'd8;
  endfunction

  // Bytes needed to carry the N x N result matrix
  function automatic int unsigned calc_bc(input int unsigned n, input int unsigned aw);
    return (n * n * aw + 32'd7) / 32'd8;
  endfunction

  // Partial sum wide enough for N full-scale products
  function automatic int unsigned calc_pw(input int unsigned n, input int unsigned ew);
    return 32'd2 * ew + 32'($clog2(n));
  endfunction

  // True when x does not fit in aw unsigned bits
  function automatic logic sat_ovf(input logic [63:0] x, input int unsigned aw);
    return (x >> aw) != 64'd0;
  endfunction

endpackage

// File: rtl/tensor_stream_mac_if.sv
// Pin-side strobe/byte bus between the I/O ring and the MAC engine.
interface tensor_stream_mac_if;

  logic [7:0] in_data;
  logic       in_wr;
  logic       out_rd;
  logic       clear;
  logic       accu;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       sat;

  modport master (
    output in_data, in_wr, out_rd, clear, accu,
    input  in_ready, out_data, out_valid, out_last, busy, sat
  );

  modport slave (
    input  in_data, in_wr, out_rd, clear, accu,
    output in_ready, out_data, out_valid, out_last, busy, sat
  );

endinterface

// File: rtl/strobe_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin strobe, followed by a rising-edge pulse.
module strobe_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_strobe,
  output logic o_pulse_c
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_strobe};
      r_prev <= r_sync[1];
    end
  end

  assign o_pulse_c = r_sync[1] & ~r_prev;

endmodule

// File: rtl/tensor_stream_mac.sv
// Byte-serial N x N matrix multiply-accumulate: loads A and B byte by byte,
// computes C = A*B or C += A*B with one MAC per cycle, and streams C back.
module tensor_stream_mac
  import tensor_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned EW = 4,
  parameter int unsigned AW = 8
) (
  input logic                clk,
  input logic                rst,
  tensor_stream_mac_if.slave io_bus
);

  localparam int unsigned BA = calc_ba(N, EW);
  localparam int unsigned BC = calc_bc(N, AW);
  localparam int unsigned PW = calc_pw(N, EW);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(((BA > BC) ? BA : BC) + 1);

  logic            w_wr_ev;
  logic            w_rd_ev;
  logic            w_clr_ev;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BA*8-1:0] r_a;
  logic [BA*8-1:0] r_b;
  logic [BC*8-1:0] r_c;
  logic [PW-1:0]   r_psum;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [IW-1:0]   r_k;
  logic [1:0]      r_accu_sync;
  logic            r_accu_mode;
  logic            r_in_ready;
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic            r_sat;

  logic [31:0]     w_byte_idx;
  logic [31:0]     w_idx_a;
  logic [31:0]     w_idx_b;
  logic [31:0]     w_idx_c;
  logic [EW-1:0]   w_a_el;
  logic [EW-1:0]   w_b_el;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_psum_next;
  logic [AW-1:0]   w_old_c;
  logic [63:0]     w_sum;
  logic            w_wb;
  logic            w_ovf;
  logic [AW-1:0]   w_c_el;
  logic [BC*8-1:0] w_c_next;

  strobe_sync_edge u_wr_sync  (.clk(clk), .rst(rst), .i_strobe(io_bus.in_wr),  .o_pulse_c(w_wr_ev));
  strobe_sync_edge u_rd_sync  (.clk(clk), .rst(rst), .i_strobe(io_bus.out_rd), .o_pulse_c(w_rd_ev));
  strobe_sync_edge u_clr_sync (.clk(clk), .rst(rst), .i_strobe(io_bus.clear),  .o_pulse_c(w_clr_ev));

  // MAC datapath and the candidate result matrix after this cycle's write-back
  always_comb begin
    w_byte_idx  = 32'd8 * 32'(r_cnt);
    w_idx_a     = (32'(r_i) * N + 32'(r_k)) * EW;
    w_idx_b     = (32'(r_k) * N + 32'(r_j)) * EW;
    w_idx_c     = (32'(r_i) * N + 32'(r_j)) * AW;
    w_a_el      = r_a[w_idx_a +: EW];
    w_b_el      = r_b[w_idx_b +: EW];
    w_prod      = PW'(w_a_el) * PW'(w_b_el);
    w_psum_next = r_psum + w_prod;
    w_wb        = (r_state == ST_COMPUTE) && (r_k == IW'(N - 1));
    w_old_c     = r_c[w_idx_c +: AW];
    w_sum       = r_accu_mode ? (64'(w_old_c) + 64'(w_psum_next)) : 64'(w_psum_next);
    w_ovf       = sat_ovf(w_sum, AW);
    w_c_el      = w_ovf ? {AW{1'b1}} : w_sum[AW-1:0];
    w_c_next    = r_c;
    if (w_wb) begin
      w_c_next[w_idx_c +: AW] = w_c_el;
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_LOAD_A;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_psum      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_accu_sync <= 2'b00;
      r_accu_mode <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_accu_sync <= {r_accu_sync[0], io_bus.accu};
      case (r_state)
        ST_LOAD_A, ST_LOAD_B: begin
          if (w_clr_ev) begin
            r_state <= ST_LOAD_A;
            r_cnt   <= '0;
            r_c     <= '0;
            r_sat   <= 1'b0;
          end else if (w_wr_ev) begin
            if (r_state == ST_LOAD_A) r_a[w_byte_idx +: 8] <= io_bus.in_data;
            else                      r_b[w_byte_idx +: 8] <= io_bus.in_data;
            if (r_cnt == CW'(BA - 1)) begin
              r_cnt <= '0;
              if (r_state == ST_LOAD_A) begin
                r_state <= ST_LOAD_B;
              end else begin
                r_state     <= ST_COMPUTE;
                r_in_ready  <= 1'b0;
                r_busy      <= 1'b1;
                r_accu_mode <= r_accu_sync[1];
                r_i         <= '0;
                r_j         <= '0;
                r_k         <= '0;
                r_psum      <= '0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          r_c <= w_c_next;
          if (w_wb) begin
            r_psum <= '0;
            r_k    <= '0;
            if (w_ovf) r_sat <= 1'b1;
            if (r_j == IW'(N - 1)) begin
              r_j <= '0;
              if (r_i == IW'(N - 1)) begin
                r_i         <= '0;
                r_state     <= ST_READ;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_last  <= (BC == 32'd1);
                r_out_data  <= w_c_next[7:0];
                r_cnt       <= '0;
              end else begin
                r_i <= r_i + IW'(1);
              end
            end else begin
              r_j <= r_j + IW'(1);
            end
          end else begin
            r_psum <= w_psum_next;
            r_k    <= r_k + IW'(1);
          end
        end
        ST_READ: begin
          // Clear takes priority over a coincident read event
          if (w_clr_ev || (w_rd_ev && r_out_last)) begin
            r_state     <= ST_LOAD_A;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= 8'h00;
            r_cnt       <= '0;
            if (w_clr_ev) begin
              r_c   <= '0;
              r_sat <= 1'b0;
            end
          end else if (w_rd_ev) begin
            r_cnt      <= r_cnt + CW'(1);
            r_out_data <= r_c[w_byte_idx + 32'd8 +: 8];
            r_out_last <= (r_cnt == CW'(BC - 2));
          end
        end
        default: r_state <= ST_LOAD_A;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.busy      = r_busy;
  assign io_bus.sat       = r_sat;

endmodule

// File: tb/tb_tensor_stream_mac.sv
// Scoreboard bench for tensor_stream_mac at default parameters (2x2, 4-bit in, 8-bit acc).
module tb_tensor_stream_mac;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] exp_q[$];
  int         m_c[4];
  bit         m_sat;

  tensor_stream_mac_if bus_if();

  tensor_stream_mac #(.N(2), .EW(4), .AW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus_if.in_data = b;
    bus_if.in_wr   = 1'b1;
    idle(4);
    bus_if.in_wr   = 1'b0;
    idle(4);
  endtask

  task automatic pulse_rd();
    bus_if.out_rd = 1'b1;
    idle(4);
    bus_if.out_rd = 1'b0;
    idle(4);
  endtask

  task automatic pulse_clr();
    bus_if.clear = 1'b1;
    idle(4);
    bus_if.clear = 1'b0;
    idle(4);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd1);
    check({tag, "_out_data"},  32'(bus_if.out_data),  32'd0);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(bus_if.out_last),  32'd0);
    check({tag, "_busy"},      32'(bus_if.busy),      32'd0);
    check({tag, "_sat"},       32'(bus_if.sat),       32'd0);
  endtask

  task automatic model_clear();
    for (int e = 0; e < 4; e++) m_c[e] = 0;
    m_sat = 1'b0;
  endtask

  // Reference C = A*B (or C + A*B), clamped to 8 bits; pushes the expected result bytes
  task automatic model_compute(input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] b0, input logic [7:0] b1, input bit acc);
    logic [15:0] am;
    logic [15:0] bm;
    int s;
    am = {a1, a0};
    bm = {b1, b0};
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s = s + int'(am[(i*2+k)*4 +: 4]) * int'(bm[(k*2+j)*4 +: 4]);
        if (acc) s = s + m_c[i*2+j];
        if (s > 255) begin
          s = 255;
          m_sat = 1'b1;
        end
        m_c[i*2+j] = s;
      end
    end
    for (int e = 0; e < 4; e++) exp_q.push_back(8'(m_c[e]));
  endtask

  // Raise in_wr with the last B byte and return at the first sample showing busy
  task automatic start_compute(input logic [7:0] b);
    int n;
    bus_if.in_data = b;
    bus_if.in_wr   = 1'b1;
    n = 0;
    while (!bus_if.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.busy) check("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_busy();
    int n;
    n = 0;
    while (bus_if.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd8);
  endtask

  task automatic load_set(input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input bit acc, input bit measure);
    bus_if.accu = acc;
    write_byte(a0);
    write_byte(a1);
    write_byte(b0);
    model_compute(a0, a1, b0, b1, acc);
    start_compute(b1);
    bus_if.in_wr = 1'b0;
    if (measure) measure_busy();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus_if.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_results(input string tag);
    logic [7:0] exp_b;
    wait_valid();
    check({tag, "_sat"}, 32'(bus_if.sat), 32'(m_sat));
    for (int e = 0; e < 4; e++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check({tag, "_data"}, 32'(bus_if.out_data), 32'(exp_b));
        check({tag, "_last"}, 32'(bus_if.out_last), 32'(e == 3));
      end
      pulse_rd();
    end
    check({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    bus_if.in_data = 8'h00;
    bus_if.in_wr   = 1'b0;
    bus_if.out_rd  = 1'b0;
    bus_if.clear   = 1'b0;
    bus_if.accu    = 1'b0;
    model_clear();

    idle(3);
    check_reset("rst");
    rst = 1'b1;
    idle(3);
    check_reset("post_rst");

    // Overwrite, then accumulate on top of the retained result
    load_set(8'h21, 8'h43, 8'h65, 8'h87, 1'b0, 1'b1);
    read_results("ovw");
    load_set(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b1);
    read_results("acc");

    // Saturation, clear drops sat and zeroes C before accumulating
    load_set(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    read_results("sat");
    pulse_clr();
    model_clear();
    check("clr_sat", 32'(bus_if.sat), 32'(m_sat));
    load_set(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b0);
    read_results("after_clr");

    // Partial load discarded by clear
    write_byte(8'hAA);
    write_byte(8'hBB);
    write_byte(8'hCC);
    pulse_clr();
    model_clear();
    check("partial_clr_ready", 32'(bus_if.in_ready), 32'd1);
    load_set(8'h21, 8'h43, 8'h65, 8'h87, 1'b0, 1'b0);
    read_results("partial");

    // Write/read/clear during COMPUTE, write during READ, reads during LOAD_A
    bus_if.accu = 1'b1;
    write_byte(8'h21);
    write_byte(8'h43);
    write_byte(8'h65);
    model_compute(8'h21, 8'h43, 8'h65, 8'h87, 1'b1);
    start_compute(8'h87);
    bus_if.in_wr  = 1'b0;
    bus_if.clear  = 1'b1;
    bus_if.out_rd = 1'b1;
    idle(3);
    bus_if.in_wr  = 1'b1;
    idle(4);
    bus_if.in_wr  = 1'b0;
    bus_if.clear  = 1'b0;
    bus_if.out_rd = 1'b0;
    wait_valid();
    idle(4);
    write_byte(8'h5A);
    if (exp_q.size() != 0) check("read_hold", 32'(bus_if.out_data), 32'(exp_q[0]));
    read_results("ignored");
    pulse_rd();
    pulse_rd();
    check("idle_rd_ready", 32'(bus_if.in_ready),  32'd1);
    check("idle_rd_valid", 32'(bus_if.out_valid), 32'd0);
    check("idle_rd_data",  32'(bus_if.out_data),  32'd0);

    // Reset in the middle of COMPUTE discards everything
    bus_if.accu = 1'b1;
    write_byte(8'h21);
    write_byte(8'h43);
    write_byte(8'h65);
    start_compute(8'h87);
    bus_if.in_wr = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
    check_reset("mid_rst");
    rst = 1'b1;
    model_clear();
    exp_q.delete();
    idle(3);
    load_set(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b1);
    read_results("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tensor_stream_mac.md
# tensor_stream_mac

Byte-serial matrix multiply-accumulate engine for pad-limited designs. Assembles two N×N operand matrices from strobed 8-bit pin writes, computes C = A·B (overwrite) or C = C + A·B (accumulate) with one MAC per cycle, and streams C back one byte per read strobe. It sits directly behind the chip I/O pins and generalises our fixed 2×2 byte-stream TPU to parametrised dimension, element width and accumulator width, adding saturation and explicit status outputs.

## Interface
- N, 2, matrix dimension (N ≥ 2)
- EW, 4, operand element width, unsigned
- AW, 8, accumulator element width, unsigned, AW ≥ 2·EW
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_data  in  8  write byte, stable from in_wr rise until 3 clk later
- in_wr  in  1  write strobe, asynchronous level, high/low ≥ 3 clk
- out_rd  in  1  read strobe, same rules as in_wr
- clear  in  1  clear strobe, same rules
- accu  in  1  level: 1 = accumulate, 0 = overwrite
- in_ready  out  1  state is LOAD_A or LOAD_B
- out_data  out  8  current result byte
- out_valid  out  1  out_data is valid (state READ)
- out_last  out  1  out_data is the final result byte
- busy  out  1  state is COMPUTE
- sat  out  1  sticky saturation flag

## Operation
- in_wr, out_rd and clear: each passes a 2-flop synchroniser followed by a rising-edge detector, producing a 1-cycle event.
- accu: 2-flop synchronised; sampled on entry to COMPUTE.
- Packing: element (i,j) occupies bits [(i·N+j)·W +: W]. Byte 0 holds bits [7:0]. Bytes per operand matrix: BA = ceil(N²·EW/8). Bytes per result: BC = ceil(N²·AW/8). Pad bits are ignored on input and driven 0 on output.
- FSM states:
  - LOAD_A: each write event stores a byte. After BA bytes → LOAD_B.
  - LOAD_B: same. After BA bytes → COMPUTE.
  - COMPUTE: counters i, j, k. Each cycle adds A[i][k]·B[k][j] into a partial sum of width 2·EW + clog2(N). When k = N−1, write back C[i][j] = accu ? sat(C[i][j] + psum) : sat(psum), then clear psum. After the last element → READ.
  - READ: presents byte r of C, starting at r = 0. Each read event increments r. A read event while out_last is high → LOAD_A.
- Saturation: values exceeding 2^AW−1 clamp to 2^AW−1 and set sat.
- Clear event:
  - In LOAD_A, LOAD_B or READ: zero C, clear sat, discard partial operand bytes, go to LOAD_A.
  - In COMPUTE: ignored.
- Ignored events:
  - Write events outside LOAD_A/LOAD_B.
  - Read events outside READ.
- Simultaneous clear and write/read events in the same cycle: clear wins.
- Reset mid-operation: all state is discarded, including C and partial bytes.

## Timing
- Reset values: state LOAD_A, in_ready 1, out_data 0, out_valid 0, out_last 0, busy 0, sat 0, C all 0.
- Event latency: a byte is captured on the 3rd rising clk edge after in_wr rises, given setup is met. Read and clear events follow the same latency.
- COMPUTE lasts N³ cycles; the last element's write-back occurs on the last of them. out_valid rises N³ cycles after the last B byte is captured (8 cycles at default).
- out_data updates in the cycle after each read event. out_data is registered.
- sat updates in the same cycle as the write-back that saturates.

## Structure
- tensor_pkg holds:
  - state enum (LOAD_A, LOAD_B, COMPUTE, READ)
  - functions for BA, BC and partial-sum width
  - the sat helper
- Sub-module strobe_sync_edge (synchroniser plus rising-edge detector), instantiated three times.
- Operand and result storage are flat registers inside tensor_stream_mac; no RAM.

## Test plan
All scenarios use default parameters.
- Reset, then write 0x21, 0x43, 0x65, 0x87 with accu = 0 → busy high for 8 cycles. Then out_valid. Reads return 0x13, 0x16, 0x2B, 0x32, with out_last on the 4th byte. Afterwards in_ready = 1.
- Repeat with accu = 1 without clear → reads return 0x26, 0x2C, 0x56, 0x64.
- Load A = B = all 0xF (0xFF, 0xFF, 0xFF, 0xFF) with accu = 0 → every byte reads 0xFF and sat = 1. A clear event → sat = 0. Then accu = 1 with the first operand set → 0x13, 0x16, 0x2B, 0x32.
- Write 3 bytes, then a clear event, then the full 4-byte first operand set → correct result 0x13, 0x16, 0x2B, 0x32; stale bytes are discarded.
- Write events during COMPUTE and READ, read events during LOAD_A, and a clear during COMPUTE → all ignored; result unchanged.
- Assert rst mid-COMPUTE → all outputs at reset values. A subsequent full operand set gives the product from scratch.
